// File: rtl/fifo_pkg.sv
// Shared widths and the partial-word byte-enable helper for the FIFO drain path.
package fifo_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_W     = BYTE_W * WORD_BYTES;

    // Low n lanes enabled; n is the count of valid bytes in a partial word.
    function automatic logic [WORD_BYTES-1:0] keep_mask(input logic [1:0] n);
        return (WORD_BYTES'(1) << n) - WORD_BYTES'(1);
    endfunction

endpackage

// File: rtl/byte_pack_timeout.sv
// Idle counter and pending-flush bookkeeping for fifo_byte_packer.
module byte_pack_timeout #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_flush,
    input  logic i_cnt_nz,
    input  logic i_fifo_empty,
    input  logic i_pop,
    input  logic i_out_free,
    output logic o_flush_req,
    output logic o_flush_pend
);

    localparam logic [TO_W-1:0] LP_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

    logic [TO_W-1:0] r_idle;
    logic            r_pend;
    logic            w_inc;
    logic            w_fire;

    assign o_flush_req  = i_flush || r_pend;
    assign o_flush_pend = r_pend;
    assign w_inc        = (TIMEOUT > 0) && i_cnt_nz && i_fifo_empty && !o_flush_req;
    assign w_fire       = w_inc && (r_idle == LP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle <= '0;
            r_pend <= 1'b0;
        end else begin
            if (w_inc) begin
                r_idle <= w_fire ? '0 : r_idle + TO_W'(1);
            end else if (i_pop || o_flush_req || !i_cnt_nz) begin
                r_idle <= '0;
            end
            // A flush that cannot emit yet stays pending until the output slot frees.
            if (o_flush_req) begin
                r_pend <= i_cnt_nz && !i_out_free;
            end else if (w_fire) begin
                r_pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_byte_packer.sv
// Drains bytes from the FIFO and packs them little-endian into 32-bit words
// on a valid/ready stream; partial words leave on flush or idle timeout.
module fifo_byte_packer
    import fifo_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BYTE_W-1:0]     fifo_data_in,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    input  logic                  flush,
    output logic [WORD_W-1:0]     out_data,
    output logic [WORD_BYTES-1:0] out_keep,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int unsigned ACC_W = (WORD_BYTES - 1) * BYTE_W;

    logic [ACC_W-1:0]      r_acc;
    logic [1:0]            r_cnt;
    logic [WORD_W-1:0]     r_out_data;
    logic [WORD_BYTES-1:0] r_out_keep;
    logic                  r_out_valid;

    logic w_out_free;
    logic w_flush_req;
    logic w_flush_pend;
    logic w_cnt_full;
    logic w_cnt_nz;
    logic w_pop;
    logic w_load_full;
    logic w_load_flush;

    assign w_out_free   = !r_out_valid || out_ready;
    assign w_cnt_full   = (r_cnt == 2'd3);
    assign w_cnt_nz     = (r_cnt != 2'd0);
    assign w_pop        = !rst && !fifo_empty && !w_flush_req && (!w_cnt_full || w_out_free);
    assign w_load_full  = w_pop && w_cnt_full;
    assign w_load_flush = w_flush_req && w_cnt_nz && w_out_free;

    assign fifo_rd   = w_pop;
    assign out_data  = r_out_data;
    assign out_keep  = r_out_keep;
    assign out_valid = r_out_valid;
    assign busy      = w_cnt_nz || r_out_valid || w_flush_pend;

    byte_pack_timeout #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (flush),
        .i_cnt_nz     (w_cnt_nz),
        .i_fifo_empty (fifo_empty),
        .i_pop        (w_pop),
        .i_out_free   (w_out_free),
        .o_flush_req  (w_flush_req),
        .o_flush_pend (w_flush_pend)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_pop && !w_cnt_full) begin
                case (r_cnt)
                    2'd0:    r_acc[BYTE_W-1:0]          <= fifo_data_in;
                    2'd1:    r_acc[2*BYTE_W-1:BYTE_W]   <= fifo_data_in;
                    default: r_acc[3*BYTE_W-1:2*BYTE_W] <= fifo_data_in;
                endcase
                r_cnt <= r_cnt + 2'd1;
            end
            // acc is cleared on every emission so flushed words carry zeros above cnt.
            if (w_load_full) begin
                r_out_data  <= {fifo_data_in, r_acc};
                r_out_keep  <= '1;
                r_out_valid <= 1'b1;
                r_acc       <= '0;
                r_cnt       <= '0;
            end else if (w_load_flush) begin
                r_out_data  <= {{BYTE_W{1'b0}}, r_acc};
                r_out_keep  <= keep_mask(r_cnt);
                r_out_valid <= 1'b1;
                r_acc       <= '0;
                r_cnt       <= '0;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Randomized and directed checks of fifo_byte_packer against a queue-based byte-stream model.
module tb_fifo_byte_packer;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        out_ready;
    logic [7:0]  fifo_data_in;
    logic        fifo_empty;
    logic        fifo_rd;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_valid;
    logic        busy;

    logic [7:0]  fifo_data_in0;
    logic        fifo_empty0;
    logic        fifo_rd0;
    logic [31:0] out_data0;
    logic [3:0]  out_keep0;
    logic        out_valid0;
    logic        busy0;

    fifo_byte_packer #(.TIMEOUT(TO), .TO_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_data_in (fifo_data_in),
        .fifo_empty   (fifo_empty),
        .fifo_rd      (fifo_rd),
        .flush        (flush),
        .out_data     (out_data),
        .out_keep     (out_keep),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy)
    );

    fifo_byte_packer #(.TIMEOUT(0), .TO_W(8)) dut0 (
        .clk          (clk),
        .rst          (rst),
        .fifo_data_in (fifo_data_in0),
        .fifo_empty   (fifo_empty0),
        .fifo_rd      (fifo_rd0),
        .flush        (flush),
        .out_data     (out_data0),
        .out_keep     (out_keep0),
        .out_valid    (out_valid0),
        .out_ready    (out_ready),
        .busy         (busy0)
    );

    always #5 clk = ~clk;

    // FIFO contents seen by each instance
    logic [7:0] fq[$];
    logic [7:0] fq0[$];

    // Reference model: bytes held, output slot, pending flush, idle streak
    logic [7:0]  m_bytes[$];
    logic        m_valid;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_pend;
    int          m_idle;

    int n_tests = 0;
    int n_fail  = 0;
    logic last_rd;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty    = (fq.size() == 0);
        fifo_data_in  = (fq.size() != 0) ? fq[0] : 8'h00;
        fifo_empty0   = (fq0.size() == 0);
        fifo_data_in0 = (fq0.size() != 0) ? fq0[0] : 8'h00;
    endtask

    task automatic model_reset();
        m_bytes.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_keep  = '0;
        m_pend  = 1'b0;
        m_idle  = 0;
    endtask

    function automatic logic [31:0] pack_bytes(input logic [7:0] b0, input logic [7:0] b1,
                                               input logic [7:0] b2, input logic [7:0] b3, input int n);
        logic [31:0] w;
        w = '0;
        if (n > 0) w = w + 32'(b0);
        if (n > 1) w = w + (32'(b1) << 8);
        if (n > 2) w = w + (32'(b2) << 16);
        if (n > 3) w = w + (32'(b3) << 24);
        return w;
    endfunction

    // One clock: apply inputs, check the pop decision, advance model and FIFO, check outputs.
    task automatic cycle(input logic fl, input logic rdy);
        int          n;
        logic        free;
        logic        freq;
        logic        exp_rd;
        logic        accept;
        logic        rd0;
        logic [7:0]  b;
        logic [7:0]  h0;
        logic [7:0]  h1;
        logic [7:0]  h2;
        flush     = fl;
        out_ready = rdy;
        drive_fifo();
        #1;
        n      = m_bytes.size();
        h0     = (n > 0) ? m_bytes[0] : 8'h00;
        h1     = (n > 1) ? m_bytes[1] : 8'h00;
        h2     = (n > 2) ? m_bytes[2] : 8'h00;
        free   = !m_valid || rdy;
        freq   = fl || m_pend;
        exp_rd = !rst && (fq.size() != 0) && !freq && (n < 3 || free);
        check_eq("fifo_rd", 32'(fifo_rd), 32'(exp_rd));
        last_rd = fifo_rd;
        rd0     = fifo_rd0;
        if (rst) begin
            model_reset();
        end else begin
            accept = m_valid && rdy;
            b      = fq.size() != 0 ? fq[0] : 8'h00;
            if (exp_rd && n == 3) begin
                m_data  = pack_bytes(h0, h1, h2, b, 4);
                m_keep  = 4'hF;
                m_valid = 1'b1;
                m_bytes.delete();
            end else if (!exp_rd && freq && n > 0 && free) begin
                m_data  = pack_bytes(h0, h1, h2, 8'h00, n);
                m_keep  = 4'((1 << n) - 1);
                m_valid = 1'b1;
                m_bytes.delete();
            end else begin
                if (exp_rd) m_bytes.push_back(b);
                if (accept) m_valid = 1'b0;
            end
            if (freq) m_pend = (n > 0) && !free;
            if (exp_rd || freq || n == 0) begin
                m_idle = 0;
            end else if (fq.size() == 0) begin
                if (m_idle + 1 == int'(TO)) begin
                    m_idle = 0;
                    m_pend = 1'b1;
                end else begin
                    m_idle = m_idle + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            fq.delete();
            fq0.delete();
        end else begin
            if (last_rd && fq.size() != 0) void'(fq.pop_front());
            if (rd0 && fq0.size() != 0) void'(fq0.pop_front());
        end
        drive_fifo();
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        check_eq("out_data", out_data, m_data);
        check_eq("out_keep", 32'(out_keep), 32'(m_keep));
        check_eq("busy", 32'(busy), 32'((m_bytes.size() != 0) || m_valid || m_pend));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b0, 1'b0);
        rst = 1'b0;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data", out_data, 32'd0);
        check_eq("rst_keep", 32'(out_keep), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rd", 32'(fifo_rd), 32'd0);
    endtask

    initial begin
        int rd_cnt;
        int lat;
        logic seen0;
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        drive_fifo();
        do_reset();

        // Stream of two full words
        for (int i = 1; i <= 8; i++) fq.push_back(8'(i * 17));
        rd_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1);
            if (last_rd) rd_cnt++;
            if (i == 2) check_eq("stream_lat3", 32'(out_valid), 32'd0);
            if (i == 3) begin
                check_eq("stream_w0", out_data, 32'h44332211);
                check_eq("stream_k0", 32'(out_keep), 32'hF);
            end
        end
        check_eq("stream_rdcnt", 32'(rd_cnt), 32'd8);
        check_eq("stream_w1", out_data, 32'h88776655);
        cycle(1'b0, 1'b1);
        check_eq("stream_drain", 32'(out_valid), 32'd0);

        // Backpressure
        do_reset();
        for (int i = 1; i <= 12; i++) fq.push_back(8'(i));
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);
        check_eq("bp_left", 32'(fq.size()), 32'd5);
        check_eq("bp_hold", out_data, 32'h04030201);
        cycle(1'b0, 1'b1);
        check_eq("bp_b2b_valid", 32'(out_valid), 32'd1);
        check_eq("bp_w1", out_data, 32'h08070605);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
        check_eq("bp_w2", out_data, 32'h0C0B0A09);

        // Flush of a 2-byte partial word
        do_reset();
        fq.push_back(8'hA1);
        fq.push_back(8'hB2);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        fq.push_back(8'hC3);
        cycle(1'b1, 1'b1);
        check_eq("flush_nopop", 32'(last_rd), 32'd0);
        check_eq("flush_data", out_data, 32'h0000B2A1);
        check_eq("flush_keep", 32'(out_keep), 32'h3);
        cycle(1'b0, 1'b1);

        // Flush while the output slot is occupied
        do_reset();
        for (int i = 1; i <= 5; i++) fq.push_back(8'(i));
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        check_eq("fpend_busy", 32'(busy), 32'd1);
        check_eq("fpend_hold", out_data, 32'h04030201);
        cycle(1'b0, 1'b1);
        check_eq("fpend_valid", 32'(out_valid), 32'd1);
        check_eq("fpend_keep", 32'(out_keep), 32'h1);
        check_eq("fpend_data", out_data, 32'h00000005);

        // Idle timeout on a 3-byte partial word
        do_reset();
        fq.push_back(8'h5A);
        fq.push_back(8'h6B);
        fq.push_back(8'h7C);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'b1);
            lat++;
            if (out_valid) break;
        end
        check_eq("timeout_lat", 32'(lat), 32'd17);
        check_eq("timeout_keep", 32'(out_keep), 32'h7);
        check_eq("timeout_data", out_data, 32'h007C6B5A);

        // Reset in the middle of a word with a held output
        do_reset();
        for (int i = 0; i < 6; i++) fq.push_back(8'(8'h21 + i));
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0);
        check_eq("midrst_pre", 32'(out_valid), 32'd1);
        do_reset();
        for (int i = 0; i < 4; i++) fq.push_back(8'(8'h31 + i));
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
        check_eq("midrst_fresh", out_data, 32'h34333231);
        check_eq("midrst_keep", 32'(out_keep), 32'hF);

        // Timeout disabled: a partial word stays put
        do_reset();
        fq0.push_back(8'hE1);
        fq0.push_back(8'hE2);
        fq0.push_back(8'hE3);
        seen0 = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b0, 1'b1);
            if (out_valid0) seen0 = 1'b1;
        end
        check_eq("to0_never", 32'(seen0), 32'd0);
        check_eq("to0_busy", 32'(busy0), 32'd1);
        check_eq("to0_popped", 32'(fq0.size()), 32'd0);
        do_reset();

        // Randomized traffic with alternating dense/sparse arrival
        for (int i = 0; i < 4000; i++) begin
            int gap;
            gap = ((i / 500) % 2 == 0) ? 1 : 12;
            if ($urandom_range(0, gap) == 0 && fq.size() < 16) fq.push_back(8'($urandom));
            cycle($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
